clk_div_multi: RTL and testbench

Parametrised multi-channel clock divider producing NUM_CH square-wave enables from the 100 MHz `sys_clk`, each with its own compile-time half-period. It also produces an optional one-cycle rising-edge strobe per channel. It replaces the fixed four-output divider in the stopwatch datapath. It adds a global run/pause enable and a synchronous phase clear, so that all divided outputs can be realigned, for example on stopwatch reset.

---
 rtl/clk_div_multi_if.sv | 24 ++
 rtl/clk_div_multi.sv | 101 ++++++++++
 tb/tb_clk_div_multi.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// Control/output bundle of the multi-channel clock divider: run enable,
// phase clear, divided square waves and their rising-edge strobes.
interface clk_div_multi_if #(
    parameter int unsigned NUM_CH = 4
);
    logic              en;
    logic              sync_clr;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    modport master (
        output en,
        output sync_clr,
        input  clk_out,
        input  tick
    );

    modport slave (
        input  en,
        input  sync_clr,
        output clk_out,
        output tick
    );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider with shared run/pause and phase clear.
// Optional feature macro: CLK_DIV_TICK_EN builds the per-channel rising-edge strobe.
module clk_div_multi #(
    parameter int unsigned                NUM_CH       = 4,
    parameter int unsigned                CNT_W        = 32,
    parameter logic [NUM_CH*CNT_W-1:0]    HALF_PERIODS = {32'd12500000, 32'd500000,
                                                          32'd25000000, 32'd50000000}
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    clk_div_multi_if.slave     bus
);

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  term_s [NUM_CH];
    logic [NUM_CH-1:0] clk_q;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] wrap_s;

    // Terminal count per channel is N_i-1; a zero half-period cannot be realised.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_term
        if (HALF_PERIODS[g*CNT_W +: CNT_W] == {CNT_W{1'b0}}) begin : g_bad_half_period
            $fatal(1, "clk_div_multi: channel %0d has half-period 0", g);
        end
        assign term_s[g] = HALF_PERIODS[g*CNT_W +: CNT_W] - {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Next counter and output state per channel: clear, then pause, then count/toggle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            clk_d[i]  = clk_q[i];
            wrap_s[i] = 1'b0;
            if (bus.sync_clr) begin
                cnt_d[i] = {CNT_W{1'b0}};
                clk_d[i] = 1'b0;
            end else if (!bus.en) begin
                cnt_d[i] = cnt_q[i];
                clk_d[i] = clk_q[i];
            end else if (cnt_q[i] == term_s[i]) begin
                cnt_d[i]  = {CNT_W{1'b0}};
                clk_d[i]  = ~clk_q[i];
                wrap_s[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Counter and divided-output registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
            clk_q <= {NUM_CH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            clk_q <= clk_d;
        end
    end

    assign bus.clk_out = clk_q;

`ifdef CLK_DIV_TICK_EN
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;

    // Strobe only on the toggle that takes the output from 0 to 1.
    always_comb begin
        tick_d = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (wrap_s[i]) begin
                tick_d[i] = ~clk_q[i];
            end else begin
                tick_d[i] = 1'b0;
            end
        end
    end

    // Strobe register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= {NUM_CH{1'b0}};
        end else begin
            tick_q <= tick_d;
        end
    end

    assign bus.tick = tick_q;
`else
    logic unused_wrap_s;

    assign unused_wrap_s = ^wrap_s;
    assign bus.tick      = {NUM_CH{1'b0}};
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a phase-count model predicts every cycle's
// outputs, a monitor compares them one cycle at a time.
module tb_clk_div_multi;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 8;
`ifdef CLK_DIV_TICK_EN
    localparam bit TICK_ON = 1'b1;
`else
    localparam bit TICK_ON = 1'b0;
`endif

    typedef struct packed {
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] tick;
    } exp_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   hp [NUM_CH] = '{1, 3, 5};
    int   k  [NUM_CH];
    exp_t q [$];

    clk_div_multi_if #(.NUM_CH(NUM_CH)) bus ();

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .HALF_PERIODS({8'd5, 8'd3, 8'd1})
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [NUM_CH-1:0] act,
                         input logic [NUM_CH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // Model: k counts edges that advanced the channel since the last clear;
    // output is high in the odd half-periods, strobe on entering each odd one.
    task automatic step(input logic e, input logic c);
        exp_t x;
        bus.en       = e;
        bus.sync_clr = c;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (c) k[ch] = 0;
            else if (e) k[ch] = k[ch] + 1;
            x.clk[ch]  = ((k[ch] / hp[ch]) % 2) == 1;
            x.tick[ch] = TICK_ON && !c && e && ((k[ch] % (2 * hp[ch])) == hp[ch]);
        end
        q.push_back(x);
        @(posedge sys_clk);
        #2;
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) k[ch] = 0;
    endtask

    // Monitor: one expected entry is consumed per clock edge that follows a step.
    initial begin
        exp_t x;
        forever begin
            @(posedge sys_clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("clk_out", bus.clk_out, x.clk);
                check("tick", bus.tick, x.tick);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en       = 1'b1;
        bus.sync_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_clk_out", bus.clk_out, 3'b000);
        check("reset_tick", bus.tick, 3'b000);
        #1;
        rst_n = 1'b1;

        // Free run from reset release.
        repeat (30) step(1'b1, 1'b0);

        // Pause with ch2 mid-count, then resume.
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        repeat (7) step(1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0);

        // One-cycle phase clear mid-run, then realigned restart.
        step(1'b1, 1'b1);
        repeat (20) step(1'b1, 1'b0);

        // Clear while ch1 is at count 2 and enabled.
        step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b0);

        // Multi-cycle clear, including with en low.
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b0);

        // Randomised enable/clear traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 4) != 0, ($urandom % 16) == 0);
        end

        // Async reset between edges while all outputs are high.
        step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        check("pre_async_all_high", bus.clk_out, 3'b111);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_clk_out", bus.clk_out, 3'b000);
        check("async_tick", bus.tick, 3'b000);
        @(posedge sys_clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        repeat (25) step(1'b1, 1'b0);

        @(posedge sys_clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
